// File: rtl/moore_seq_gen.sv
// Stimulus generator for the Moore P1/P2 detector: drives CODE symbol by symbol,
// then samples the detector's z for up to Z_TIMEOUT cycles and reports pass/fail.
module moore_seq_gen #(
  parameter int unsigned          SEQ_LEN   = 4,
  parameter logic [SEQ_LEN-1:0]   CODE      = 4'b1100,
  parameter int unsigned          HOLD      = 1,
  parameter int unsigned          GAP       = 0,
  parameter int unsigned          Z_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       z,
  output logic       P1,
  output logic       P2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] sym_idx
);

  localparam int unsigned MAX_HG = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned MAXC   = (MAX_HG > Z_TIMEOUT) ? MAX_HG : Z_TIMEOUT;
  localparam int unsigned CW     = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0] HOLD_END = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_END  = (GAP == 0) ? '0 : CW'(GAP - 1);
  localparam logic [CW-1:0] Z_END    = CW'(Z_TIMEOUT - 1);
  localparam logic [3:0]    LAST     = 4'(SEQ_LEN - 1);

  // Code left-aligned in 16 bits so symbol i is always bit 15-i.
  localparam logic [15:0] CODE_ALN = 16'(CODE) << (16 - SEQ_LEN);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP, S_WAIT_Z} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    sym_q;
  logic          p1_q, p2_q, busy_q, done_q, pass_q;

  function automatic logic sym_bit(input logic [3:0] idx);
    return CODE_ALN[4'd15 - idx];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sym_q   <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_DRIVE;
            cnt_q   <= '0;
            sym_q   <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            p1_q    <= sym_bit(4'd0);
            p2_q    <= ~sym_bit(4'd0);
          end
        end
        S_DRIVE: begin
          if (cnt_q == HOLD_END) begin
            cnt_q <= '0;
            if (sym_q == LAST) begin
              state_q <= S_WAIT_Z;
              p1_q    <= 1'b0;
              p2_q    <= 1'b0;
            end else if (GAP > 0) begin
              state_q <= S_GAP;
              p1_q    <= 1'b0;
              p2_q    <= 1'b0;
            end else begin
              sym_q <= sym_q + 4'd1;
              p1_q  <= sym_bit(sym_q + 4'd1);
              p2_q  <= ~sym_bit(sym_q + 4'd1);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_END) begin
            state_q <= S_DRIVE;
            cnt_q   <= '0;
            sym_q   <= sym_q + 4'd1;
            p1_q    <= sym_bit(sym_q + 4'd1);
            p2_q    <= ~sym_bit(sym_q + 4'd1);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_Z: begin
          if (z || cnt_q == Z_END) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sym_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= z;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign P1      = p1_q;
  assign P2      = p2_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign sym_idx = sym_q;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Bench for moore_seq_gen: a default-parameter instance and a HOLD=2/GAP=1 instance,
// checked every cycle against a timing-formula model plus hand-computed waveforms.
module tb_moore_seq_gen;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       start = '0;
  logic [1:0]       z = '0;
  logic [1:0]       p1, p2, busy, done, pass;
  logic [1:0][3:0]  sym;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  moore_seq_gen u_def (
    .clk(clk), .reset(rst), .start(start[0]), .z(z[0]),
    .P1(p1[0]), .P2(p2[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .sym_idx(sym[0])
  );

  moore_seq_gen #(.SEQ_LEN(3), .CODE(3'b101), .HOLD(2), .GAP(1), .Z_TIMEOUT(4)) u_gap (
    .clk(clk), .reset(rst), .start(start[1]), .z(z[1]),
    .P1(p1[1]), .P2(p2[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .sym_idx(sym[1])
  );

  int unsigned PH[2] = '{1, 2};
  int unsigned PG[2] = '{0, 1};
  int unsigned PL[2] = '{4, 3};
  int unsigned PC[2] = '{12, 5};
  int unsigned PZ[2] = '{4, 4};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a run is an edge count k since acceptance; outputs follow from the timing rules.
  bit m_run[2], m_done[2], m_pass[2];
  int m_k[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_done[d] = 0; m_pass[d] = 0; m_k[d] = 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      int tw;
      tw = PL[d] * PH[d] + (PL[d] - 1) * PG[d];
      if (rst) begin
        m_run[d] = 0; m_done[d] = 0; m_pass[d] = 0; m_k[d] = 0;
      end else begin
        m_done[d] = 0;
        if (!m_run[d]) begin
          if (start[d]) begin
            m_run[d] = 1; m_k[d] = 0; m_pass[d] = 0;
          end
        end else begin
          m_k[d]++;
          if (m_k[d] > tw) begin
            if (z[d]) begin
              m_done[d] = 1; m_pass[d] = 1; m_run[d] = 0;
            end else if (m_k[d] == tw + PZ[d]) begin
              m_done[d] = 1; m_pass[d] = 0; m_run[d] = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int tw, i, r, b, ep1, ep2, esym;
      bit chk_sym;
      tw = PL[d] * PH[d] + (PL[d] - 1) * PG[d];
      ep1 = 0; ep2 = 0; esym = 0; chk_sym = 1;
      if (m_run[d]) begin
        if (m_k[d] < tw) begin
          i = m_k[d] / (PH[d] + PG[d]);
          r = m_k[d] % (PH[d] + PG[d]);
          if (r < PH[d]) begin
            b = (PC[d] >> (PL[d] - 1 - i)) & 1;
            ep1 = b; ep2 = 1 - b;
          end
          esym = i;
        end else begin
          chk_sym = 0;
        end
      end
      chk($sformatf("m%0d_P1", d), p1[d], ep1);
      chk($sformatf("m%0d_P2", d), p2[d], ep2);
      chk($sformatf("m%0d_busy", d), busy[d], m_run[d]);
      chk($sformatf("m%0d_done", d), done[d], m_done[d]);
      chk($sformatf("m%0d_pass", d), pass[d], m_pass[d]);
      chk($sformatf("m%0d_excl", d), p1[d] & p2[d], 0);
      if (chk_sym) chk($sformatf("m%0d_sym", d), sym[d], esym);
    end
  end

  task automatic go(input int d);
    start[d] = 1'b1;
    @(posedge clk);
  endtask

  int exp_p1[7]  = '{2, 2, 1, 1, 0, 0, 0};
  int exp_p3[9]  = '{2, 2, 0, 1, 1, 0, 2, 2, 0};
  int exp_s3[8]  = '{0, 0, 0, 1, 1, 1, 2, 2};
  int ndone;

  initial begin
    @(negedge clk);
    chk("rst_P1", p1[0], 0); chk("rst_P2", p2[0], 0); chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0); chk("rst_pass", pass[0], 0); chk("rst_sym", sym[0], 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: defaults, detector answers z after t0+4
    go(0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) start[0] = 1'b0;
      chk($sformatf("t1_P_k%0d", k), {p1[0], p2[0]}, exp_p1[k]);
      chk($sformatf("t1_busy_k%0d", k), busy[0], (k <= 4) ? 1 : 0);
      chk($sformatf("t1_done_k%0d", k), done[0], (k == 5) ? 1 : 0);
      if (k == 5) chk("t1_pass", pass[0], 1);
      if (k == 4) z[0] = 1'b1;
      if (k == 5) z[0] = 1'b0;
    end

    // 2: z stays low, timeout after t0+8
    go(0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) start[0] = 1'b0;
      chk($sformatf("t2_done_k%0d", k), done[0], (k == 8) ? 1 : 0);
      if (k == 8) chk("t2_pass", pass[0], 0);
    end

    // 3: HOLD=2 GAP=1 CODE=101
    go(1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) start[1] = 1'b0;
      if (k < 9) chk($sformatf("t3_P_k%0d", k), {p1[1], p2[1]}, exp_p3[k]);
      if (k < 8) chk($sformatf("t3_sym_k%0d", k), sym[1], exp_s3[k]);
      chk($sformatf("t3_done_k%0d", k), done[1], (k == 12) ? 1 : 0);
    end

    // 4a: second start pulse while busy is ignored
    ndone = 0;
    go(0);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      start[0] = (k == 1) ? 1'b1 : 1'b0;
      ndone += done[0];
    end
    chk("t4a_done_count", ndone, 1);

    // 4b: start held high, new run on edge after done
    go(0);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 4) z[0] = 1'b1;
      if (k == 5) begin
        z[0] = 1'b0;
        chk("t4b_done", done[0], 1);
        chk("t4b_pass1", pass[0], 1);
      end
      if (k == 6) begin
        chk("t4b_rebusy", busy[0], 1);
        chk("t4b_pass0", pass[0], 0);
        chk("t4b_P", {p1[0], p2[0]}, 2);
        start[0] = 1'b0;
      end
    end

    // 5: asynchronous reset mid-DRIVE
    go(0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) start[0] = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    chk("t5_P1", p1[0], 0); chk("t5_P2", p2[0], 0);
    chk("t5_busy", busy[0], 0); chk("t5_sym", sym[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      ndone += done[0];
    end
    chk("t5_no_done", ndone, 0);
    go(0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) start[0] = 1'b0;
      if (k < 5) chk($sformatf("t5_P_k%0d", k), {p1[0], p2[0]}, exp_p1[k]);
      if (k == 4) z[0] = 1'b1;
      if (k == 5) begin
        z[0] = 1'b0;
        chk("t5_done", done[0], 1);
        chk("t5_pass", pass[0], 1);
      end
    end

    // 6: z high only during DRIVE is ignored
    z[0] = 1'b1;
    go(0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) start[0] = 1'b0;
      if (k == 4) z[0] = 1'b0;
      chk($sformatf("t6_done_k%0d", k), done[0], (k == 8) ? 1 : 0);
      if (k == 8) chk("t6_pass", pass[0], 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moore_seq_gen.md
# moore_seq_gen

Transmit-side companion to the `Moore` P1/P2 sequence detector. On a `start` request it drives a parameterised code onto `P1`/`P2`, one symbol at a time. It then watches the detector's `z` output and reports whether the code was recognised within a timeout. It serves as the on-board stimulus source and self-check for the detector.

## Interface
Parameters:
- `SEQ_LEN`, 4: number of symbols in the code. Legal range is 1..16.
- `CODE`, 4'b1100: `SEQ_LEN`-bit code. Bit `SEQ_LEN-1` is sent first. A 1 sends P1 (`P1`=1, `P2`=0); a 0 sends P2 (`P1`=0, `P2`=1).
- `HOLD`, 1: clock cycles each symbol is held. Must be ≥1.
- `GAP`, 0: idle cycles (`P1`=`P2`=0) inserted between symbols. Never inserted after the last symbol.
- `Z_TIMEOUT`, 4: cycles spent sampling `z` after the last symbol. Must be ≥1.

Ports:
- `clk`  in  1  single clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to transmit; sampled only in IDLE.
- `z`  in  1  recognition output from the detector.
- `P1`  out  1  symbol line P1, registered.
- `P2`  out  1  symbol line P2, registered.
- `busy`  out  1  high from start acceptance until completion, registered.
- `done`  out  1  one-cycle completion pulse, registered.
- `pass`  out  1  result; valid while `done`=1, held until the next acceptance.
- `sym_idx`  out  4  index of the symbol currently driven, 0-based. Reads 0 in IDLE.

## Operation
- Reset (asynchronous assert, takes effect immediately):
  - State goes to IDLE.
  - `P1`, `P2`, `busy`, `done`, `pass` = 0; `sym_idx` = 0; all counters cleared.
- States:
  - **IDLE**: `P1`=`P2`=0, `busy`=0. If `start`=1 at an edge, go to DRIVE with `sym_idx`=0 and `busy`=1.
  - **DRIVE**: drive symbol `CODE[SEQ_LEN-1-sym_idx]` for `HOLD` cycles.
    - After the last hold cycle, if `sym_idx`=`SEQ_LEN-1`, go to WAIT_Z.
    - Else if `GAP`>0, go to GAP.
    - Else go to DRIVE with `sym_idx`+1.
  - **GAP**: `P1`=`P2`=0 for `GAP` cycles, then go to DRIVE with `sym_idx`+1.
  - **WAIT_Z**: `P1`=`P2`=0; sample `z` on each edge, up to `Z_TIMEOUT` edges.
    - First edge with `z`=1: `done`=1, `pass`=1, `busy`=0, go to IDLE.
    - `Z_TIMEOUT` edges with `z`=0: `done`=1, `pass`=0, `busy`=0, go to IDLE.
- `z` is ignored outside WAIT_Z. A premature `z` during DRIVE or GAP does not count as a match.
- `start` is ignored while `busy`=1. No queuing.
- `P1` and `P2` are never both 1.
- `pass` clears to 0 on the edge that accepts the next `start`.
- Counters are sized for `max(HOLD, GAP, Z_TIMEOUT)` and must not wrap within a phase.

## Timing
- Let t0 be the edge that samples `start`=1 in IDLE.
- Symbol 0 appears on `P1`/`P2` immediately after t0; there is no extra latency cycle.
- Symbol i is driven from edge t0 + i·(`HOLD`+`GAP`) for `HOLD` cycles.
- WAIT_Z is entered at tW = t0 + `SEQ_LEN`·`HOLD` + (`SEQ_LEN`-1)·`GAP`.
- `z` is sampled at edges tW+1 through tW+`Z_TIMEOUT`. `done` rises on the sampling edge that ends the wait.
- The cycle in which `done`=1 is IDLE. A `start`=1 sampled at the next edge is accepted, so back-to-back runs are legal.
- With default parameters, a correct detector asserts `z` after edge t0+4. The generator samples it at t0+5, so `done`=1, `pass`=1 follows t0+5.
- Reset mid-run: outputs drop to 0 without waiting for a clock edge. No `done` pulse is produced for the aborted run.
- After reset releases, the first `start` sampled is accepted normally.

## Test plan
1. **Defaults, pulse start, ideal detector model.**
   - `P1`/`P2` are 10,10,01,01 at cycles t0..t0+3, then 00.
   - `z` rises at t0+5, giving `done`=1, `pass`=1 for exactly one cycle.
   - `busy` is high from t0 through t0+5.
2. **`z` held at 0.**
   - `done`=1, `pass`=0 after edge tW+4 = t0+8.
   - `P1`=`P2`=0 throughout WAIT_Z.
3. **`HOLD`=2, `GAP`=1, `CODE`=3'b101, `SEQ_LEN`=3.**
   - Sequence is 10,10,00,01,01,00,10,10, then WAIT_Z at t0+8.
   - `sym_idx` steps 0,0,0,1,1,1,2,2.
4. **`start` pulsed again at t0+2 while busy.**
   - The pulse is ignored; only one `done` is produced.
   - **`start` held high continuously.**
     - A new run begins on the edge after `done`.
     - `pass` reads 0 from that edge onward.
5. **`reset` asserted mid-DRIVE at t0+2, between edges.**
   - `P1`, `P2`, `busy`, `sym_idx` go to 0 immediately.
   - No `done` is produced.
   - A `start` after reset releases produces a full, correct sequence.
6. **`z`=1 forced during DRIVE only.**
   - It is ignored; the run ends with `pass`=0 at timeout.
